// File: rtl/vit_frame_sched.sv
// Round-robin frame scheduler sharing one (2,1,3) Viterbi decoder between two channels.
// Whole frames are granted; tail symbols are padded and hung frames are aborted by a watchdog.
//
// state | meaning
// IDLE  | no frame owned; arbitrate pending requests
// START | one-cycle decoder start pulse; frame counters cleared
// RUN   | feeding symbols on le, returning decoded bits on oe
// DONE  | FRAME_LEN bits returned; release the decoder
// ABORT | watchdog expired; release the decoder
module vit_frame_sched #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL      = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] sym0,
    input  logic [1:0] sym1,
    output logic       sym_rd0,
    output logic       sym_rd1,
    output logic       seq_ready,
    output logic [1:0] rx_sym,
    input  logic       le,
    input  logic       oe,
    input  logic       Dx,
    output logic [1:0] grant,
    output logic       dec_bit,
    output logic       dec_valid,
    output logic       dec_ch,
    output logic       frame_done,
    output logic       abort
);

    localparam int SW = $clog2(FRAME_LEN + TAIL + 1);
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam logic [SW-1:0] SYM_N   = SW'(FRAME_LEN);
    localparam logic [SW-1:0] SYM_MAX = SW'(FRAME_LEN + TAIL);
    localparam logic [BW-1:0] BIT_N   = BW'(FRAME_LEN);
    localparam logic [7:0]    WD_MAX  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_q, last_d;
    logic [SW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      wd_q, wd_d;
    logic            dec_bit_q, dec_bit_d;
    logic            dec_valid_q, dec_valid_d;
    logic            dec_ch_q, dec_ch_d;

    logic ch;
    logic sym_live;

    assign ch       = grant_q[1];
    assign sym_live = (sym_cnt_q < SYM_N);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            sym_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            wd_q        <= 8'd0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_ch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            sym_cnt_q   <= sym_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            wd_q        <= wd_d;
            dec_bit_q   <= dec_bit_d;
            dec_valid_q <= dec_valid_d;
            dec_ch_q    <= dec_ch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        sym_cnt_d   = sym_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        wd_d        = wd_q;
        dec_bit_d   = dec_bit_q;
        dec_valid_d = 1'b0;
        dec_ch_d    = dec_ch_q;
        seq_ready   = 1'b0;
        frame_done  = 1'b0;
        abort       = 1'b0;
        sym_rd0     = 1'b0;
        sym_rd1     = 1'b0;
        rx_sym      = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        grant_d = last_q ? 2'b01 : 2'b10;
                    end else begin
                        grant_d = req0 ? 2'b01 : 2'b10;
                    end
                    state_d = S_START;
                end
            end
            S_START: begin
                seq_ready = 1'b1;
                sym_cnt_d = '0;
                bit_cnt_d = '0;
                wd_d      = 8'd0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Past FRAME_LEN real symbols the decoder is fed zero tail pads.
                rx_sym = sym_live ? (ch ? sym1 : sym0) : 2'b00;
                if (le) begin
                    if (sym_live) begin
                        sym_rd0 = ~ch;
                        sym_rd1 = ch;
                    end
                    if (sym_cnt_q != SYM_MAX) begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
                if (oe && (bit_cnt_q < BIT_N)) begin
                    dec_bit_d   = Dx;
                    dec_ch_d    = ch;
                    dec_valid_d = 1'b1;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                end
                wd_d = (le || oe) ? 8'd0 : wd_q + 8'd1;
                if (bit_cnt_d == BIT_N) begin
                    state_d = S_DONE;
                end else if (wd_d == WD_MAX) begin
                    state_d = S_ABORT;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                last_d     = ch;
                grant_d    = 2'b00;
                state_d    = S_IDLE;
            end
            S_ABORT: begin
                abort   = 1'b1;
                last_d  = ch;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant     = grant_q;
    assign dec_bit   = dec_bit_q;
    assign dec_valid = dec_valid_q;
    assign dec_ch    = dec_ch_q;

endmodule

// File: tb/tb_vit_frame_sched.sv
// Randomized scoreboard bench for vit_frame_sched: the driver predicts pops, decoded bits,
// starts and frame endings from per-frame counts; a negedge monitor checks what the DUT shows.
module tb_vit_frame_sched;

    localparam int N    = 64;
    localparam int TAIL = 2;
    localparam int TMO  = 255;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] sym0, sym1;
    logic       le, oe, Dx;
    logic       sym_rd0, sym_rd1, seq_ready;
    logic [1:0] rx_sym, grant;
    logic       dec_bit, dec_valid, dec_ch, frame_done, abort;

    vit_frame_sched #(.FRAME_LEN(N), .TAIL(TAIL), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .sym0       (sym0),
        .sym1       (sym1),
        .sym_rd0    (sym_rd0),
        .sym_rd1    (sym_rd1),
        .seq_ready  (seq_ready),
        .rx_sym     (rx_sym),
        .le         (le),
        .oe         (oe),
        .Dx         (Dx),
        .grant      (grant),
        .dec_bit    (dec_bit),
        .dec_valid  (dec_valid),
        .dec_ch     (dec_ch),
        .frame_done (frame_done),
        .abort      (abort)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { bit rd0; bit rd1; logic [1:0] sym; } le_t;
    typedef struct { bit ch; bit b; int cyc; } dec_t;
    typedef struct { bit ab; int cyc; } end_t;
    typedef struct { logic [1:0] g; int cyc; } start_t;

    le_t    le_q[$];
    dec_t   dec_q[$];
    end_t   end_q[$];
    start_t start_q[$];

    int checks   = 0;
    int failures = 0;
    bit last_srv;
    bit gz_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_seq_ready"}, seq_ready, 0);
        chk({tag, "_sym_rd0"}, sym_rd0, 0);
        chk({tag, "_sym_rd1"}, sym_rd1, 0);
        chk({tag, "_rx_sym"}, rx_sym, 0);
        chk({tag, "_dec_bit"}, dec_bit, 0);
        chk({tag, "_dec_valid"}, dec_valid, 0);
        chk({tag, "_dec_ch"}, dec_ch, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_abort"}, abort, 0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents the matching output.
    initial begin
        le_t    e;
        dec_t   d;
        end_t   f;
        start_t s;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (gz_pend) begin
                    chk("grant_released", grant, 0);
                    gz_pend = 1'b0;
                end
                if (le) begin
                    if (le_q.size() == 0) begin
                        chk("le_unexpected", 1, 0);
                    end else begin
                        e = le_q.pop_front();
                        chk("sym_rd0", sym_rd0, e.rd0);
                        chk("sym_rd1", sym_rd1, e.rd1);
                        chk("rx_sym", rx_sym, e.sym);
                    end
                end else if (sym_rd0 || sym_rd1) begin
                    chk("sym_rd_without_le", {sym_rd1, sym_rd0}, 0);
                end
                if (seq_ready) begin
                    if (start_q.size() == 0) begin
                        chk("seq_ready_unexpected", 1, 0);
                    end else begin
                        s = start_q.pop_front();
                        chk("start_grant", grant, s.g);
                        chk("start_cycle", cyc, s.cyc);
                    end
                end
                if (dec_valid) begin
                    if (dec_q.size() == 0) begin
                        chk("dec_valid_unexpected", 1, 0);
                    end else begin
                        d = dec_q.pop_front();
                        chk("dec_ch", dec_ch, d.ch);
                        chk("dec_bit", dec_bit, d.b);
                        chk("dec_cycle", cyc, d.cyc);
                    end
                end
                if (frame_done || abort) begin
                    if (end_q.size() == 0) begin
                        chk("frame_end_unexpected", {abort, frame_done}, 0);
                    end else begin
                        f = end_q.pop_front();
                        chk("end_kind_abort", abort, f.ab);
                        chk("end_kind_done", frame_done, !f.ab);
                        chk("end_cycle", cyc, f.cyc);
                        gz_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // mode 0: normal, 1: normal plus stray oe after the frame, 2: decoder stall, 3: reset mid-RUN
    task automatic run_frame(input bit r0, input bit r1, input int mode);
        bit     own;
        int     tot = 0;
        int     bc = 0;
        int     ref_c;
        int     k = 0;
        int     stall_after;
        int     exp_c;
        start_t s;
        le_t    e;
        dec_t   d;
        end_t   f;

        own = (r0 && r1) ? ~last_srv : r1;
        stall_after = $urandom_range(0, 5);
        req0 = r0;
        req1 = r1;
        s.g   = own ? 2'b10 : 2'b01;
        s.cyc = cyc + 1;
        start_q.push_back(s);
        while (!seq_ready && k < 8) begin
            step();
            k++;
        end
        if (!seq_ready) begin
            failures++;
            $display("FAIL seq_ready_timeout actual=0 expected=1 time=%0t", $time);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1);
        end
        ref_c    = cyc;
        req0     = 1'b0;
        req1     = 1'b0;
        last_srv = own;

        forever begin
            step();
            sym0 = 2'($urandom);
            sym1 = 2'($urandom);
            Dx   = 1'($urandom);
            if (mode == 2 && tot >= stall_after) begin
                le = 1'b0;
                oe = 1'b0;
                break;
            end
            if (mode == 3 && tot == 10) begin
                le = 1'b0;
                oe = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_vals("mid_reset");
                le_q.delete();
                dec_q.delete();
                end_q.delete();
                start_q.delete();
                gz_pend = 1'b0;
                step();
                step();
                reset = 1'b0;
                last_srv = 1'b1;
                step();
                return;
            end
            le = ($urandom % 4) != 0;
            oe = (($urandom % 3) == 0) && (bc + TAIL < tot);
            if (le) begin
                e.rd0 = (tot < N) && !own;
                e.rd1 = (tot < N) && own;
                e.sym = (tot < N) ? (own ? sym1 : sym0) : 2'b00;
                le_q.push_back(e);
                tot++;
                ref_c = cyc;
            end
            if (oe) begin
                d.ch  = own;
                d.b   = Dx;
                d.cyc = cyc + 1;
                dec_q.push_back(d);
                bc++;
                ref_c = cyc;
                if (bc == N) begin
                    f.ab  = 1'b0;
                    f.cyc = cyc + 1;
                    end_q.push_back(f);
                    break;
                end
            end
        end

        if (mode == 2) begin
            exp_c = ref_c + 1 + TMO;
            f.ab  = 1'b1;
            f.cyc = exp_c;
            end_q.push_back(f);
            while (cyc < exp_c + 1) step();
        end else begin
            step();
            le = 1'b0;
            oe = (mode == 1);
            step();
            oe = (mode == 1);
            step();
            oe = 1'b0;
        end
        repeat ($urandom_range(0, 2)) step();
    endtask

    initial begin
        bit r0, r1;
        #2000000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        bit r0, r1;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        sym0 = 2'b00; sym1 = 2'b00;
        le = 1'b0; oe = 1'b0; Dx = 1'b0;
        last_srv = 1'b1;
        gz_pend = 1'b0;
        repeat (3) step();
        check_reset_vals("por");
        reset = 1'b0;
        step();

        run_frame(1'b1, 1'b0, 0);
        repeat (4) run_frame(1'b1, 1'b1, 0);
        run_frame(1'b0, 1'b1, 1);
        run_frame(1'b1, 1'b1, 1);
        run_frame(1'b1, 1'b1, 2);
        run_frame(1'b1, 1'b1, 0);
        run_frame(1'b1, 1'b0, 3);
        run_frame(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1'b1;
            run_frame(r0, r1, int'($urandom_range(0, 1)));
        end
        run_frame(1'b0, 1'b1, 2);
        run_frame(1'b1, 1'b1, 0);

        repeat (5) step();
        chk("le_queue_drained", le_q.size(), 0);
        chk("dec_queue_drained", dec_q.size(), 0);
        chk("end_queue_drained", end_q.size(), 0);
        chk("start_queue_drained", start_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vit_frame_sched.md
Name: vit_frame_sched

Overview:
- Round-robin frame scheduler that shares one (2,1,3) Viterbi decoder core between two symbol-source channels.
- Grants whole frames only: a frame runs from decoder start until FRAME_LEN decoded bits have been returned.
- Sits between the channel front-ends and the decoder control unit. It drives seq_ready and the received-symbol bus, and consumes le, oe and Dx.
- Routes decoded bits back to the owning channel, pads tail symbols, and aborts hung frames with a watchdog.

Parameters:
- FRAME_LEN, 64: decoded bits per frame (N); range 1..255.
- TAIL, 2: memory order m; number of zero tail symbols fed after FRAME_LEN real symbols.
- TIMEOUT, 255: max idle cycles (no le and no oe) in RUN before abort; 8-bit counter.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- req0  in  1  channel 0 has a full frame ready (level)
- req1  in  1  channel 1 has a full frame ready (level)
- sym0  in  2  channel 0 current received symbol pair
- sym1  in  2  channel 1 current received symbol pair
- sym_rd0  out  1  pop strobe to channel 0
- sym_rd1  out  1  pop strobe to channel 1
- seq_ready  out  1  start pulse to decoder
- rx_sym  out  2  symbol pair to decoder branch-metric unit
- le  in  1  decoder load strobe (consumes one symbol)
- oe  in  1  decoder output strobe
- Dx  in  1  decoded bit, valid when oe=1
- grant  out  2  one-hot owner of decoder; 00 when idle
- dec_bit  out  1  registered decoded bit
- dec_valid  out  1  registered bit-valid strobe
- dec_ch  out  1  channel of dec_bit
- frame_done  out  1  1-cycle pulse, frame completed normally
- abort  out  1  1-cycle pulse, frame aborted by watchdog

Behaviour:
- Reset (async, active-high; clock is clock): state=IDLE; grant=00; seq_ready, sym_rd0/1, dec_valid, frame_done, abort, dec_bit, dec_ch=0; rx_sym=00; last-served pointer=1, so ch0 wins the first tie. All counters=0. Reset mid-frame discards the frame silently, with no frame_done and no abort.
- States: IDLE, START, RUN, DONE, ABORT.
- IDLE: if any req is high, register grant, then go to START.
  - Both requests high: grant the channel not last served.
  - Single request: grant that channel.
- START: seq_ready=1 for exactly one cycle; clear sym_cnt, bit_cnt and wd_cnt; go to RUN.
- RUN, input side:
  - rx_sym is combinational: granted channel's sym while sym_cnt < FRAME_LEN, else 00 (tail pad).
  - On le=1 with sym_cnt < FRAME_LEN: sym_rd of the granted channel =1 in the same cycle (combinational); sym_cnt increments.
  - On le=1 with sym_cnt >= FRAME_LEN: no sym_rd; the pad symbol is consumed; sym_cnt saturates at FRAME_LEN+TAIL.
  - Channels never see more than FRAME_LEN pops per frame.
- RUN, output side:
  - On oe=1: dec_bit<=Dx, dec_ch<=granted index, dec_valid<=1 next cycle (latency 1); bit_cnt increments.
  - oe seen after bit_cnt==FRAME_LEN is ignored: no dec_valid.
  - When bit_cnt reaches FRAME_LEN, go to DONE.
- Watchdog: wd_cnt clears on any le or oe in RUN, else increments. At wd_cnt==TIMEOUT, go to ABORT.
- Simultaneous le and oe in one cycle: both processed.
- req deasserting mid-frame is ignored; the frame runs to completion.
- DONE: frame_done=1 for one cycle; last-served<=granted; grant<=00; go to IDLE.
  - A new grant is possible no earlier than 2 cycles after frame_done.
- ABORT: abort=1 for one cycle; last-served<=granted; grant<=00; go to IDLE. Partial decoded bits already emitted stay valid.
- sym_rd0 and sym_rd1 are never both high; sym_rd is only high in RUN.

Test Plan:
- Reset, req0=1 only → grant=01 one cycle after req; seq_ready pulses once next cycle; 64 le pulses → exactly 64 sym_rd0, rx_sym=00 on le #65,#66; 64 oe with Dx pattern → 64 dec_valid with dec_ch=0 and matching bits, one cycle late; frame_done once; grant=00.
- req0 and req1 high together after reset → frames served ch0, ch1, ch0, ch1; sym_rd1 never high during a ch0 frame.
- Frame with oe count >64 → only 64 dec_valid, the extra oe ignored, frame_done after bit 64.
- Decoder stalls (no le/oe) for 255 cycles in RUN → abort pulse at cycle 255 idle, grant=00, next frame goes to the other channel.
- Assert reset mid-RUN after 10 symbols → all outputs at reset values immediately; next req0 restarts with sym_cnt=0 and a fresh seq_ready.
- le and oe asserted in the same cycle → one sym_rd and one dec_valid (next cycle); both counters advance by 1.
